// File: rtl/witf_pkg.sv
// Shared definitions for the write-in-flight table: default depth, pointer
// width, register-index width and the register address type.
package witf_pkg;

   localparam int WITF_DEPTH_DEF = 4;
   localparam int WITF_PTR_W_DEF = $clog2(WITF_DEPTH_DEF);
   localparam int REG_IDX_W      = 5;

   typedef logic [REG_IDX_W-1:0] RegAddrBus;

   function automatic int witf_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/witf_if.sv
// Decode/dispatch/writeback bundle of the write-in-flight table.
// master = pipeline side (drives indices and strobes), slave = the table.
interface witf_if
   import witf_pkg::*;
#(
   parameter int DEPTH = WITF_DEPTH_DEF
) ();

   localparam int CNT_W = witf_cnt_width(DEPTH);

   RegAddrBus        rs1;
   RegAddrBus        rs2;
   RegAddrBus        rd;
   logic             disp_en;
   logic             wb_en;
   RegAddrBus        wb_rd;
   logic             isRAW;
   logic             witf_full;
   logic             witf_empty;
   logic [CNT_W-1:0] witf_cnt;
   logic             witf_err;

   modport master (
      output rs1, rs2, rd, disp_en, wb_en, wb_rd,
      input  isRAW, witf_full, witf_empty, witf_cnt, witf_err
   );

   modport slave (
      input  rs1, rs2, rd, disp_en, wb_en, wb_rd,
      output isRAW, witf_full, witf_empty, witf_cnt, witf_err
   );

endinterface

// File: rtl/witf_match.sv
// DEPTH-way compare of one source register index against the table entries.
// Masked entries never hit; index 0 (the zero register) never hits.
module witf_match
   import witf_pkg::*;
#(
   parameter int DEPTH = WITF_DEPTH_DEF
) (
   input  RegAddrBus                          src,
   input  logic [DEPTH-1:0]                   valid,
   input  logic [DEPTH-1:0][REG_IDX_W-1:0]    entry_rd,
   input  logic [DEPTH-1:0]                   mask,
   output logic                               hit
);

   logic [DEPTH-1:0] eq;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign eq[gi] = valid[gi] && !mask[gi] && (entry_rd[gi] == src);
      end
   endgenerate

   assign hit = (src != '0) && (|eq);

endmodule

// File: rtl/witf.sv
// Write-in-flight table: in-order circular FIFO of destination registers used
// to flag RAW hazards at decode. Optional macro WITF_RETIRE_BYPASS_EN masks the
// retiring head entry from isRAW since the register file forwards that write.
module witf
   import witf_pkg::*;
#(
   parameter int DEPTH = WITF_DEPTH_DEF
) (
   input logic   clk,
   input logic   rst,
   witf_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = witf_cnt_width(DEPTH);

   logic [DEPTH-1:0]                valid_q, valid_d;
   logic [DEPTH-1:0][REG_IDX_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0]                head_q, head_d;
   logic [PTR_W-1:0]                tail_q, tail_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            err_q, err_d;

   logic             full;
   logic             empty;
   logic             pop_ok;
   logic             push_ok;
   logic [DEPTH-1:0] bypass_mask;
   logic             hit_rs1;
   logic             hit_rs2;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      pop_ok  = bus.wb_en && !empty;
      // A full table accepts a dispatch only when the head retires alongside it.
      push_ok = bus.disp_en && (bus.rd != '0) && (!full || pop_ok);

      if (pop_ok) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (push_ok) begin
         valid_d[tail_q] = 1'b1;
         rd_d[tail_q]    = bus.rd;
         tail_d          = tail_q + PTR_W'(1);
      end

      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      if (bus.wb_en && empty) begin
         err_d = 1'b1;
      end
      if (pop_ok && (rd_q[head_q] != bus.wb_rd)) begin
         err_d = 1'b1;
      end
      if (bus.disp_en && (bus.rd != '0) && !push_ok) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      bypass_mask = '0;
`ifdef WITF_RETIRE_BYPASS_EN
      if (pop_ok) begin
         bypass_mask[head_q] = 1'b1;
      end
`else
      bypass_mask = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         rd_q    <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rd_q    <= rd_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   witf_match #(.DEPTH(DEPTH)) u_match_rs1 (
      .src      (bus.rs1),
      .valid    (valid_q),
      .entry_rd (rd_q),
      .mask     (bypass_mask),
      .hit      (hit_rs1)
   );

   witf_match #(.DEPTH(DEPTH)) u_match_rs2 (
      .src      (bus.rs2),
      .valid    (valid_q),
      .entry_rd (rd_q),
      .mask     (bypass_mask),
      .hit      (hit_rs2)
   );

   assign bus.isRAW      = hit_rs1 || hit_rs2;
   assign bus.witf_full  = full;
   assign bus.witf_empty = empty;
   assign bus.witf_cnt   = cnt_q;
   assign bus.witf_err   = err_q;

endmodule
